multi_commit_rob: RTL and testbench
===================================

MULTI_COMMIT_ROB -- requirements
Module: multi_commit_rob

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- NUM_ENTRY, 32, ROB depth; power of two, at least 4.
- DISP_W, 2, dispatch lanes per cycle.
- COMMIT_W, 2, commit lanes per cycle.
- WB_PORTS, 4, writeback ports.
- ID_W, $clog2(NUM_ENTRY), ROB index width.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, sole clock; all state changes on its rising edge.
- rst, in, 1, asynchronous, active-low reset.
- flush, in, 1, external pipeline flush.
- disp_entry, in, DISP_W x ROB_ENTRY_t, dispatch payloads.
- disp_valid, in, DISP_W, per-lane dispatch request.
- disp_ready, out, 1, all DISP_W lanes may dispatch this cycle.
- disp_rob_id, out, DISP_W x ID_W, ROB index assigned to each lane.
- wb_valid, in, WB_PORTS, writeback strobe per port.
- wb_rob_id, in, WB_PORTS x ID_W, entry being completed.
- wb_mispredict, in, WB_PORTS, branch resolved mispredicted.
- wb_target, in, WB_PORTS x 32, actual branch target.
- commit_valid, out, COMMIT_W, per-lane retire strobe.
- commit_entry, out, COMMIT_W x ROB_ENTRY_t, retired payloads (rd_arch, rd_phy_old, rd_phy_new, store_id).
- redirect_valid, out, 1, a mispredicted entry retired.
- redirect_pc, out, 32, target for redirect.
- rob_count, out, ID_W+1, occupied entries.
- rob_empty, out, 1, rob_count == 0.

Function
REQ-003 head/tail SHALL be ID_W+1 bits with a wrap bit: full when the low bits are equal and the wrap bits differ; empty when fully equal; natural modulo wrap.
REQ-004 disp_ready SHALL be 1 iff free entries (NUM_ENTRY - rob_count) >= DISP_W, evaluated from registered count only.
REQ-005 disp_valid SHALL be contiguous from lane 0; lane k receives tail+k (mod NUM_ENTRY), and disp_rob_id is combinational and valid in the same cycle.
REQ-006 Dispatch with disp_ready=0 SHALL be ignored; no entry written, tail unchanged.
REQ-007 A written entry SHALL have finished=0, mispredict=0.
REQ-008 Writeback SHALL set finished (plus mispredict and target) one cycle after wb_valid; a writeback to an unoccupied index SHALL be ignored.
REQ-009 On the same index in one cycle, the highest-numbered port SHALL win.
REQ-010 Each cycle, commit SHALL retire the longest finished prefix starting at head, up to COMMIT_W entries; commit_valid is contiguous from lane 0.
REQ-011 Commit outputs SHALL be combinational from registered state; head advances by the retire count at the next edge.
REQ-012 A retired mispredicted entry SHALL be the last lane retired that cycle, with:
- redirect_valid=1 that cycle and redirect_pc=its target;
- all entries cleared (head=tail=0, count=0) at the next edge.
REQ-013 Same-cycle dispatch and commit SHALL update count by +dispatched - retired.
REQ-014 flush SHALL clear all entries next edge and suppress same-cycle commit_valid, redirect_valid and dispatch writes; flush has priority over writeback.
REQ-015 Writeback to an entry retiring in the same cycle SHALL be ignored.

Reset
REQ-016 On rst=0, asynchronously:
- head, tail, count = 0; all finished/mispredict bits = 0;
- commit_valid = 0, redirect_valid = 0, redirect_pc = 0, disp_ready = 1, rob_empty = 1.
REQ-017 Reset mid-operation SHALL discard all in-flight entries with no commit pulse on release.

Structure
REQ-018 ROB_ENTRY_t, the writeback struct, and the default NUM_ENTRY/DISP_W/COMMIT_W SHALL reside in typedef_pkg.
REQ-019 Finished-prefix selection SHALL be a sub-module rob_commit_select (inputs: rotated finished/mispredict vectors; outputs: lane mask, redirect lane).
REQ-020 Payload storage SHALL be a flat register array without reset; status bits are resettable.

Verification
REQ-021 The bench SHALL cover:
- Reset, dispatch 2/cycle for 16 cycles (NUM_ENTRY=32) -> rob_count=32, disp_ready=0 at count 31, ids 0..31 in order.
- Out-of-order writeback of ids 3,1,0,2 -> commits {0,1} then {2,3}; no commit before id 0 is finished.
- Wrap: 40 dispatch/commit pairs -> ids wrap 31->0, count never exceeds 32, empty at end.
- Mispredict on id 5 (target 0x80) with 5..8 finished -> lanes retire 4,5 only; redirect_valid=1, pc=0x80; next cycle rob_empty=1.
- flush together with dispatch and pending commit -> no commit_valid, count=0 next cycle.
- rst low mid-stream -> outputs at reset values immediately; no commit after release.

Source files
------------

// File: rtl/typedef_pkg.sv
// Shared types for the multi-commit reorder buffer: retired payload, writeback info,
// default geometry and a small population-count helper.
package typedef_pkg;

    localparam int NUM_ENTRY_DEF = 32;
    localparam int DISP_W_DEF    = 2;
    localparam int COMMIT_W_DEF  = 2;

    localparam int ARCH_W     = 5;
    localparam int PHY_W      = 7;
    localparam int STORE_ID_W = 4;

    typedef struct packed {
        logic [ARCH_W-1:0]     rd_arch;
        logic [PHY_W-1:0]      rd_phy_old;
        logic [PHY_W-1:0]      rd_phy_new;
        logic [STORE_ID_W-1:0] store_id;
    } ROB_ENTRY_t;

    typedef struct packed {
        logic        mispredict;
        logic [31:0] target;
    } WB_INFO_t;

    function automatic logic [7:0] count_ones(input logic [31:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + 8'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/rob_commit_select.sv
// Picks the longest finished run starting at the ROB head; a mispredicted entry
// ends the run and is reported as the redirect lane.
module rob_commit_select #(
    parameter int COMMIT_W = 2,
    parameter int LANE_W   = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
    input  logic [COMMIT_W-1:0] fin_rot,
    input  logic [COMMIT_W-1:0] mis_rot,
    output logic [COMMIT_W-1:0] lane_mask,
    output logic                redirect_hit,
    output logic [LANE_W-1:0]   redirect_lane
);

    logic run;

    always_comb begin
        lane_mask     = '0;
        redirect_hit  = 1'b0;
        redirect_lane = '0;
        run           = 1'b1;
        for (int j = 0; j < COMMIT_W; j++) begin
            run          = run & fin_rot[j];
            lane_mask[j] = run;
            // a retiring mispredict is always the final lane of the run
            if (run && mis_rot[j]) begin
                redirect_hit  = 1'b1;
                redirect_lane = LANE_W'(j);
            end
            run = run & ~mis_rot[j];
        end
    end

endmodule

// File: rtl/multi_commit_rob.sv
// Multi-dispatch / multi-commit reorder buffer with out-of-order writeback,
// in-order retirement and mispredict redirect.
module multi_commit_rob
    import typedef_pkg::*;
#(
    parameter int NUM_ENTRY = NUM_ENTRY_DEF,
    parameter int DISP_W    = DISP_W_DEF,
    parameter int COMMIT_W  = COMMIT_W_DEF,
    parameter int WB_PORTS  = 4,
    parameter int ID_W      = $clog2(NUM_ENTRY)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  ROB_ENTRY_t [DISP_W-1:0]            disp_entry,
    input  logic [DISP_W-1:0]                  disp_valid,
    output logic                               disp_ready,
    output logic [DISP_W-1:0][ID_W-1:0]        disp_rob_id,
    input  logic [WB_PORTS-1:0]                wb_valid,
    input  logic [WB_PORTS-1:0][ID_W-1:0]      wb_rob_id,
    input  logic [WB_PORTS-1:0]                wb_mispredict,
    input  logic [WB_PORTS-1:0][31:0]          wb_target,
    output logic [COMMIT_W-1:0]                commit_valid,
    output ROB_ENTRY_t [COMMIT_W-1:0]          commit_entry,
    output logic                               redirect_valid,
    output logic [31:0]                        redirect_pc,
    output logic [ID_W:0]                      rob_count,
    output logic                               rob_empty
);

    localparam int CNT_W  = ID_W + 1;
    localparam int LANE_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

    logic [CNT_W-1:0]     head_reg, head_next;
    logic [CNT_W-1:0]     tail_reg, tail_next;
    logic [NUM_ENTRY-1:0] finished_reg, finished_next;
    logic [NUM_ENTRY-1:0] mispred_reg, mispred_next;

    ROB_ENTRY_t  payload_mem [NUM_ENTRY];
    logic [31:0] target_mem  [NUM_ENTRY];

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] n_disp;
    logic [CNT_W-1:0] n_commit;
    logic             clear_all;

    // pointer difference with wrap bit gives occupancy directly
    assign count      = tail_reg - head_reg;
    assign rob_count  = count;
    assign rob_empty  = (count == '0);
    assign disp_ready = (NUM_ENTRY - int'(count)) >= DISP_W;

    // ---------------- dispatch ----------------
    logic [DISP_W-1:0] disp_lane_we;
    logic              disp_run;

    for (genvar gi = 0; gi < DISP_W; gi++) begin : g_disp_id
        assign disp_rob_id[gi] = tail_reg[ID_W-1:0] + ID_W'(gi);
    end

    always_comb begin
        disp_lane_we = '0;
        disp_run     = disp_ready & ~flush;
        for (int k = 0; k < DISP_W; k++) begin
            disp_run        = disp_run & disp_valid[k];
            disp_lane_we[k] = disp_run;
        end
    end

    assign n_disp = CNT_W'(count_ones(32'(disp_lane_we)));

    // ---------------- commit ----------------
    logic [COMMIT_W-1:0]           fin_rot;
    logic [COMMIT_W-1:0]           mis_rot;
    logic [COMMIT_W-1:0]           commit_mask;
    logic [COMMIT_W-1:0][ID_W-1:0] commit_idx;
    logic                          redirect_hit;
    logic [LANE_W-1:0]             redirect_lane;

    for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_commit_lane
        assign commit_idx[gi]   = head_reg[ID_W-1:0] + ID_W'(gi);
        assign fin_rot[gi]      = finished_reg[commit_idx[gi]] & (count > CNT_W'(gi));
        assign mis_rot[gi]      = mispred_reg[commit_idx[gi]];
        assign commit_entry[gi] = payload_mem[commit_idx[gi]];
    end

    rob_commit_select #(
        .COMMIT_W (COMMIT_W),
        .LANE_W   (LANE_W)
    ) u_commit_select (
        .fin_rot       (fin_rot),
        .mis_rot       (mis_rot),
        .lane_mask     (commit_mask),
        .redirect_hit  (redirect_hit),
        .redirect_lane (redirect_lane)
    );

    assign commit_valid   = flush ? '0 : commit_mask;
    assign redirect_valid = redirect_hit & ~flush;
    assign redirect_pc    = redirect_valid ? target_mem[commit_idx[redirect_lane]] : 32'h0;
    assign n_commit       = CNT_W'(count_ones(32'(commit_valid)));
    assign clear_all      = flush | redirect_valid;

    // ---------------- writeback ----------------
    WB_INFO_t [WB_PORTS-1:0]       wb_info;
    logic [WB_PORTS-1:0][ID_W-1:0] wb_off;
    logic [WB_PORTS-1:0]           wb_accept;

    for (genvar gi = 0; gi < WB_PORTS; gi++) begin : g_wb
        assign wb_info[gi] = {wb_mispredict[gi], wb_target[gi]};
        assign wb_off[gi]  = wb_rob_id[gi] - head_reg[ID_W-1:0];
        // accept only occupied entries that are not leaving this cycle
        assign wb_accept[gi] = wb_valid[gi]
                             & ({1'b0, wb_off[gi]} >= n_commit)
                             & ({1'b0, wb_off[gi]} < count);
    end

    // ---------------- next state ----------------
    always_comb begin
        head_next     = head_reg + n_commit;
        tail_next     = tail_reg + n_disp;
        finished_next = finished_reg;
        mispred_next  = mispred_reg;
        for (int k = 0; k < DISP_W; k++) begin
            if (disp_lane_we[k]) begin
                finished_next[disp_rob_id[k]] = 1'b0;
                mispred_next[disp_rob_id[k]]  = 1'b0;
            end
        end
        // ascending order lets the highest-numbered port win on a shared index
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_accept[p]) begin
                finished_next[wb_rob_id[p]] = 1'b1;
                mispred_next[wb_rob_id[p]]  = wb_info[p].mispredict;
            end
        end
        if (clear_all) begin
            head_next     = '0;
            tail_next     = '0;
            finished_next = '0;
            mispred_next  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            finished_reg <= '0;
            mispred_reg  <= '0;
        end else begin
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            finished_reg <= finished_next;
            mispred_reg  <= mispred_next;
        end
    end

    // payload and targets are only meaningful while the status bits say so
    always_ff @(posedge clk) begin
        for (int k = 0; k < DISP_W; k++) begin
            if (disp_lane_we[k]) begin
                payload_mem[disp_rob_id[k]] <= disp_entry[k];
            end
        end
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_accept[p]) begin
                target_mem[wb_rob_id[p]] <= wb_info[p].target;
            end
        end
    end

endmodule

// File: tb/tb_multi_commit_rob.sv
// Randomised and directed bench for multi_commit_rob, checked against an in-order
// queue model of in-flight instructions through a per-cycle scoreboard.
module tb_multi_commit_rob;
    import typedef_pkg::*;

    localparam int NE = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    ROB_ENTRY_t [1:0]     disp_entry;
    logic [1:0]           disp_valid;
    logic                 disp_ready;
    logic [1:0][4:0]      disp_rob_id;
    logic [3:0]           wb_valid;
    logic [3:0][4:0]      wb_rob_id;
    logic [3:0]           wb_mispredict;
    logic [3:0][31:0]     wb_target;
    logic [1:0]           commit_valid;
    ROB_ENTRY_t [1:0]     commit_entry;
    logic                 redirect_valid;
    logic [31:0]          redirect_pc;
    logic [5:0]           rob_count;
    logic                 rob_empty;

    multi_commit_rob dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .disp_entry     (disp_entry),
        .disp_valid     (disp_valid),
        .disp_ready     (disp_ready),
        .disp_rob_id    (disp_rob_id),
        .wb_valid       (wb_valid),
        .wb_rob_id      (wb_rob_id),
        .wb_mispredict  (wb_mispredict),
        .wb_target      (wb_target),
        .commit_valid   (commit_valid),
        .commit_entry   (commit_entry),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .rob_count      (rob_count),
        .rob_empty      (rob_empty)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int          id;
        ROB_ENTRY_t  pay;
        bit          fin;
        bit          mis;
        logic [31:0] tgt;
    } m_ent_t;

    typedef struct {
        int          count;
        bit          ready;
        logic [1:0]  cv;
        ROB_ENTRY_t  ce [2];
        bit          rv;
        logic [31:0] rpc;
        int          did [2];
    } exp_t;

    m_ent_t m_q [$];
    int     m_tail;
    exp_t   sb_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluate this cycle's expected outputs from the driven inputs, then advance the model.
    task automatic model_step();
        exp_t   e;
        m_ent_t ne;
        int     nret;
        bit     redir;
        bit     stop;
        e.count  = m_q.size();
        e.ready  = (NE - m_q.size()) >= 2;
        e.did[0] = m_tail % NE;
        e.did[1] = (m_tail + 1) % NE;
        e.cv     = '0;
        e.ce[0]  = '0;
        e.ce[1]  = '0;
        e.rv     = 1'b0;
        e.rpc    = '0;
        nret  = 0;
        redir = 1'b0;
        stop  = flush;
        for (int j = 0; j < 2; j++) begin
            if (!stop && j < m_q.size() && m_q[j].fin) begin
                e.cv[j] = 1'b1;
                e.ce[j] = m_q[j].pay;
                nret++;
                if (m_q[j].mis) begin
                    redir = 1'b1;
                    e.rv  = 1'b1;
                    e.rpc = m_q[j].tgt;
                    stop  = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
        sb_q.push_back(e);

        if (flush || redir) begin
            m_q.delete();
            m_tail = 0;
        end else begin
            for (int p = 0; p < 4; p++) begin
                if (wb_valid[p]) begin
                    for (int k = nret; k < m_q.size(); k++) begin
                        if (m_q[k].id == int'(wb_rob_id[p])) begin
                            m_q[k].fin = 1'b1;
                            m_q[k].mis = wb_mispredict[p];
                            m_q[k].tgt = wb_target[p];
                        end
                    end
                end
            end
            repeat (nret) void'(m_q.pop_front());
            if (e.ready) begin
                for (int k = 0; k < 2; k++) begin
                    if (disp_valid[k]) begin
                        ne.id  = m_tail % NE;
                        ne.pay = disp_entry[k];
                        ne.fin = 1'b0;
                        ne.mis = 1'b0;
                        ne.tgt = '0;
                        m_q.push_back(ne);
                        m_tail++;
                    end
                end
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("rob_count", 64'(rob_count), 64'(e.count));
            chk("rob_empty", 64'(rob_empty), 64'(e.count == 0));
            chk("disp_ready", 64'(disp_ready), 64'(e.ready));
            chk("disp_rob_id0", 64'(disp_rob_id[0]), 64'(e.did[0]));
            chk("disp_rob_id1", 64'(disp_rob_id[1]), 64'(e.did[1]));
            chk("commit_valid", 64'(commit_valid), 64'(e.cv));
            for (int j = 0; j < 2; j++) begin
                if (e.cv[j]) chk("commit_entry", 64'(commit_entry[j]), 64'(e.ce[j]));
            end
            chk("redirect_valid", 64'(redirect_valid), 64'(e.rv));
            if (e.rv) chk("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
            $display("cycle t=%0t count=%0d cv=%b rv=%b", $time, rob_count, commit_valid, redirect_valid);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        flush         = 1'b0;
        disp_valid    = '0;
        wb_valid      = '0;
        wb_rob_id     = '0;
        wb_mispredict = '0;
        wb_target     = '0;
    endtask

    task automatic rand_payload();
        logic [31:0] r;
        for (int k = 0; k < 2; k++) begin
            r = $urandom;
            disp_entry[k] = r[$bits(ROB_ENTRY_t)-1:0];
        end
    endtask

    task automatic set_wb(input int p, input int id, input bit mis, input logic [31:0] tgt);
        wb_valid[p]      = 1'b1;
        wb_rob_id[p]     = 5'(id);
        wb_mispredict[p] = mis;
        wb_target[p]     = tgt;
    endtask

    // Inputs are already driven (posedge+1); record expectation and advance one clock.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst_out(input string tag);
        chk({tag, "_commit_valid"}, 64'(commit_valid), 64'd0);
        chk({tag, "_redirect_valid"}, 64'(redirect_valid), 64'd0);
        chk({tag, "_redirect_pc"}, 64'(redirect_pc), 64'd0);
        chk({tag, "_disp_ready"}, 64'(disp_ready), 64'd1);
        chk({tag, "_rob_empty"}, 64'(rob_empty), 64'd1);
        chk({tag, "_rob_count"}, 64'(rob_count), 64'd0);
    endtask

    task automatic rand_cycle();
        int n;
        idle();
        rand_payload();
        n = $urandom_range(0, 2);
        disp_valid = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
        flush = ($urandom_range(0, 99) < 2);
        for (int p = 0; p < 4; p++) begin
            if ($urandom_range(0, 99) < 40) begin
                if (m_q.size() > 0 && $urandom_range(0, 99) < 85)
                    set_wb(p, m_q[$urandom_range(0, m_q.size() - 1)].id,
                           $urandom_range(0, 99) < 4, $urandom);
                else
                    set_wb(p, $urandom_range(0, NE - 1), $urandom_range(0, 99) < 4, $urandom);
            end
        end
        cycle();
    endtask

    task automatic drain();
        for (int it = 0; it < 60 && m_q.size() > 0; it++) begin
            idle();
            for (int p = 0; p < 4 && p < m_q.size(); p++) set_wb(p, m_q[p].id, 1'b0, 32'h0);
            cycle();
        end
        idle();
        cycle();
    endtask

    task automatic reset_mid();
        #6;
        rst = 1'b0;
        #1;
        check_rst_out("rst_mid");
        m_q.delete();
        m_tail = 0;
        disp_valid = 2'b11;
        wb_valid   = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_rst_out("rst_hold");
        idle();
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst = 1'b0;
        idle();
        disp_entry = '0;
        m_tail = 0;
        #2;
        check_rst_out("rst_init");
        #21;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // fill: 16 cycles of two dispatches
        for (int c = 0; c < 16; c++) begin
            idle();
            rand_payload();
            disp_valid = 2'b11;
            cycle();
        end

        // out-of-order writeback 3,1,0,2 on a full ROB; first dispatch must be ignored
        idle(); rand_payload(); disp_valid = 2'b11; set_wb(0, 3, 1'b0, 32'h0); cycle();
        idle(); set_wb(1, 1, 1'b0, 32'h0); cycle();
        idle(); set_wb(2, 0, 1'b0, 32'h0); cycle();
        idle(); set_wb(3, 2, 1'b0, 32'h0); cycle();
        idle(); cycle();
        idle(); set_wb(0, 4, 1'b0, 32'h0); cycle();
        idle(); cycle();
        // climb to 31 entries, then a blocked dispatch
        for (int c = 0; c < 3; c++) begin
            idle(); rand_payload(); disp_valid = 2'b11; cycle();
        end
        drain();

        // wrap: 40 single dispatch / writeback pairs
        for (int c = 0; c < 40; c++) begin
            idle();
            rand_payload();
            disp_valid = 2'b01;
            if (m_q.size() > 0) set_wb(0, m_q[0].id, 1'b0, 32'h0);
            cycle();
        end
        drain();

        // mispredict on id 5
        idle(); flush = 1'b1; cycle();
        for (int c = 0; c < 5; c++) begin
            idle(); rand_payload(); disp_valid = 2'b11; cycle();
        end
        idle();
        set_wb(0, 5, 1'b1, 32'h80);
        set_wb(1, 6, 1'b0, 32'h0);
        set_wb(2, 7, 1'b0, 32'h0);
        set_wb(3, 8, 1'b0, 32'h0);
        cycle();
        idle();
        for (int p = 0; p < 4; p++) set_wb(p, p, 1'b0, 32'h0);
        cycle();
        idle(); set_wb(0, 4, 1'b0, 32'h0); cycle();
        idle(); cycle();
        idle(); cycle();
        idle(); cycle();

        // flush with dispatch and a pending commit
        for (int c = 0; c < 2; c++) begin
            idle(); rand_payload(); disp_valid = 2'b11; cycle();
        end
        idle(); set_wb(0, 0, 1'b0, 32'h0); set_wb(1, 1, 1'b0, 32'h0); cycle();
        idle(); rand_payload(); disp_valid = 2'b11; flush = 1'b1; cycle();
        idle(); cycle();

        // random traffic with a reset in the middle
        for (int c = 0; c < 300; c++) rand_cycle();
        reset_mid();
        idle(); cycle();
        for (int c = 0; c < 300; c++) rand_cycle();
        drain();
        idle(); cycle();

        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
